// File: rtl/reg_file_mp_pkg.sv
// rf_pkg: shared clear-FSM state type and register-file default sizing.
package rf_pkg;
  typedef enum logic {IDLE, CLEAR} clr_state_e;
  localparam int RF_DATA_W   = 32;
  localparam int RF_DEPTH    = 32;
  localparam int RF_LINK_REG = RF_DEPTH - 1;
endpackage

// File: rtl/reg_file_mp_if.sv
// reg_file_mp_if: read/write/link/scoreboard/clear bus of the multi-port register file.
import rf_pkg::*;
interface reg_file_mp_if #(
  parameter int DATA_W = RF_DATA_W,
  parameter int DEPTH  = RF_DEPTH,
  parameter int NUM_RD = 2
);
  localparam int AW = $clog2(DEPTH);
  logic [NUM_RD*AW-1:0]     rd_addr_i;
  logic [NUM_RD*DATA_W-1:0] rd_data_o;
  logic [NUM_RD-1:0]        rd_pend_o;
  logic                     wr_en_i;
  logic [AW-1:0]            wr_addr_i;
  logic [DATA_W-1:0]        wr_data_i;
  logic                     link_en_i;
  logic [DATA_W-1:0]        link_data_i;
  logic                     pend_set_i;
  logic [AW-1:0]            pend_addr_i;
  logic                     clr_i;
  logic                     clr_busy_o;
  modport master (
    output rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, link_en_i, link_data_i,
           pend_set_i, pend_addr_i, clr_i,
    input  rd_data_o, rd_pend_o, clr_busy_o
  );
  modport slave (
    input  rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, link_en_i, link_data_i,
           pend_set_i, pend_addr_i, clr_i,
    output rd_data_o, rd_pend_o, clr_busy_o
  );
endinterface

// File: rtl/reg_file_mp_clear_seq.sv
// rf_clear_seq: sweeps registers 1..DEPTH-1 to zero, one per cycle, after a clr_i pulse.
import rf_pkg::*;
module rf_clear_seq #(
  parameter int DEPTH = RF_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  output logic          start_o,
  output logic          clr_en_o,
  output logic [AW-1:0] clr_addr_o,
  output logic          busy_o
);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  clr_state_e    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE) begin
      if (clr_i) begin
        state_d = CLEAR;
        cnt_d   = AW'(1);
      end
    end else begin
      state_d = (cnt_q == LAST) ? IDLE : CLEAR;
      cnt_d   = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end
  assign start_o    = (state_q == IDLE) && clr_i;
  assign busy_o     = (state_q == CLEAR);
  assign clr_en_o   = busy_o;
  assign clr_addr_o = cnt_q;
endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with link port, write bypass, pending scoreboard
// and a background clear sweep.
import rf_pkg::*;
module reg_file_mp #(
  parameter int DATA_W   = RF_DATA_W,
  parameter int DEPTH    = RF_DEPTH,
  parameter int NUM_RD   = 2,
  parameter int LINK_REG = DEPTH - 1,
  parameter bit BYPASS   = 1'b1,
  localparam int AW = $clog2(DEPTH)
) (
  input logic          clk_i,
  input logic          rst_i,
  reg_file_mp_if.slave bus
);
  localparam logic [AW-1:0] LINK_A = AW'(LINK_REG);
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  pend_q, pend_d;
  logic              start, clr_en, busy;
  logic [AW-1:0]     clr_addr;
  logic              wr_ok, link_ok, pset_ok;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_pend;
  rf_clear_seq #(.DEPTH(DEPTH)) u_clr (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (bus.clr_i),
    .start_o    (start),
    .clr_en_o   (clr_en),
    .clr_addr_o (clr_addr),
    .busy_o     (busy)
  );
  assign wr_ok   = !busy && bus.wr_en_i && (bus.wr_addr_i != '0);
  assign link_ok = !busy && bus.link_en_i && (LINK_A != '0);
  assign pset_ok = !busy && bus.pend_set_i && (bus.pend_addr_i != '0);
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      regs_q <= '{default: '0};
      pend_q <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
    end
  end
  // Link is applied after the general write so it wins on LINK_REG; a pend set wins over
  // the write-clear, and a sweep start wipes the whole scoreboard.
  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    if (clr_en) regs_d[clr_addr] = '0;
    if (wr_ok) begin
      regs_d[bus.wr_addr_i] = bus.wr_data_i;
      pend_d[bus.wr_addr_i] = 1'b0;
    end
    if (link_ok) begin
      regs_d[LINK_A] = bus.link_data_i;
      pend_d[LINK_A] = 1'b0;
    end
    if (pset_ok) pend_d[bus.pend_addr_i] = 1'b1;
    if (start) pend_d = '0;
    regs_d[0] = '0;
    pend_d[0] = 1'b0;
  end
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0] a;
    assign a = bus.rd_addr_i[k*AW +: AW];
    assign rd_pend[k] = pend_q[a];
    assign rd_data[k*DATA_W +: DATA_W] =
      (a == '0)                               ? '0 :
      (BYPASS && link_ok && a == LINK_A)      ? bus.link_data_i :
      (BYPASS && wr_ok && a == bus.wr_addr_i) ? bus.wr_data_i :
                                                regs_q[a];
  end
  assign bus.rd_data_o  = rd_data;
  assign bus.rd_pend_o  = rd_pend;
  assign bus.clr_busy_o = busy;
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: scoreboard bench for reg_file_mp, BYPASS=1 and BYPASS=0 instances side by side.
module tb_reg_file_mp;
  logic clk = 1'b0;
  logic rst_i = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  int          adr_q[$];
  always #5 clk = ~clk;
  reg_file_mp_if bus ();
  reg_file_mp_if bus0 ();
  reg_file_mp #(.BYPASS(1'b1)) dut (.clk_i(clk), .rst_i(rst_i), .bus(bus.slave));
  reg_file_mp #(.BYPASS(1'b0)) dut0 (.clk_i(clk), .rst_i(rst_i), .bus(bus0.slave));
  assign bus0.rd_addr_i   = bus.rd_addr_i;
  assign bus0.wr_en_i     = bus.wr_en_i;
  assign bus0.wr_addr_i   = bus.wr_addr_i;
  assign bus0.wr_data_i   = bus.wr_data_i;
  assign bus0.link_en_i   = bus.link_en_i;
  assign bus0.link_data_i = bus.link_data_i;
  assign bus0.pend_set_i  = bus.pend_set_i;
  assign bus0.pend_addr_i = bus.pend_addr_i;
  assign bus0.clr_i       = bus.clr_i;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int p0, input int p1);
    bus.rd_addr_i = {5'(p1), 5'(p0)};
    #1;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    bus.wr_en_i   = 1'b1;
    bus.wr_addr_i = 5'(a);
    bus.wr_data_i = d;
  endtask

  task automatic test_reset;
    logic [31:0] e;
    bus.rd_addr_i = '0; bus.wr_en_i = 0; bus.wr_addr_i = '0; bus.wr_data_i = '0;
    bus.link_en_i = 0; bus.link_data_i = '0; bus.pend_set_i = 0; bus.pend_addr_i = '0;
    bus.clr_i = 0;
    rst_i = 1'b0;
    #3;
    set_rd(0, 17);
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    e = exp_q.pop_front(); checks++;
    if (bus.rd_data_o[31:0] !== e) begin errors++; $display("FAIL reset_rd0: got %h exp %h", bus.rd_data_o[31:0], e); end
    e = exp_q.pop_front(); checks++;
    if (bus.rd_data_o[63:32] !== e) begin errors++; $display("FAIL reset_rd17: got %h exp %h", bus.rd_data_o[63:32], e); end
    checks++;
    if (bus.rd_pend_o !== 2'b00) begin errors++; $display("FAIL reset_pend: got %b exp 00", bus.rd_pend_o); end
    checks++;
    if (bus.clr_busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", bus.clr_busy_o); end
    tick;
    rst_i = 1'b1;
    tick;
  endtask

  task automatic test_write_read;
    logic [31:0] e;
    wr(5, 32'hDEADBEEF); exp_q.push_back(32'hDEADBEEF);
    tick;
    bus.wr_en_i = 0;
    set_rd(5, 0);
    e = exp_q.pop_front(); checks++;
    if (bus.rd_data_o[31:0] !== e) begin errors++; $display("FAIL wr_r5: got %h exp %h", bus.rd_data_o[31:0], e); end
    wr(0, 32'h1234); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    set_rd(0, 0);
    e = exp_q.pop_front(); checks++;
    if (bus.rd_data_o[31:0] !== e) begin errors++; $display("FAIL r0_nobypass: got %h exp %h", bus.rd_data_o[31:0], e); end
    tick;
    bus.wr_en_i = 0;
    set_rd(0, 0);
    e = exp_q.pop_front(); checks++;
    if (bus.rd_data_o[31:0] !== e) begin errors++; $display("FAIL r0_zero: got %h exp %h", bus.rd_data_o[31:0], e); end
  endtask

  task automatic test_bypass;
    logic [31:0] e;
    wr(7, 32'hA5A5A5A5); exp_q.push_back(32'hA5A5A5A5); exp_q.push_back(32'h0);
    set_rd(0, 7);
    e = exp_q.pop_front(); checks++;
    if (bus.rd_data_o[63:32] !== e) begin errors++; $display("FAIL bypass1: got %h exp %h", bus.rd_data_o[63:32], e); end
    e = exp_q.pop_front(); checks++;
    if (bus0.rd_data_o[63:32] !== e) begin errors++; $display("FAIL bypass0: got %h exp %h", bus0.rd_data_o[63:32], e); end
    exp_q.push_back(32'hA5A5A5A5);
    tick;
    bus.wr_en_i = 0;
    set_rd(0, 7);
    e = exp_q.pop_front(); checks++;
    if (bus0.rd_data_o[63:32] !== e) begin errors++; $display("FAIL stored_r7: got %h exp %h", bus0.rd_data_o[63:32], e); end
  endtask

  task automatic test_link;
    logic [31:0] e;
    wr(3, 32'h33);
    tick;
    wr(31, 32'h11);
    bus.link_en_i = 1; bus.link_data_i = 32'h400;
    exp_q.push_back(32'h400); exp_q.push_back(32'h0);
    set_rd(31, 31);
    e = exp_q.pop_front(); checks++;
    if (bus.rd_data_o[31:0] !== e) begin errors++; $display("FAIL link_bypass_prio: got %h exp %h", bus.rd_data_o[31:0], e); end
    e = exp_q.pop_front(); checks++;
    if (bus0.rd_data_o[31:0] !== e) begin errors++; $display("FAIL link_nobypass: got %h exp %h", bus0.rd_data_o[31:0], e); end
    exp_q.push_back(32'h400); exp_q.push_back(32'h33);
    tick;
    bus.wr_en_i = 0; bus.link_en_i = 0;
    set_rd(31, 3);
    e = exp_q.pop_front(); checks++;
    if (bus.rd_data_o[31:0] !== e) begin errors++; $display("FAIL link_prio_r31: got %h exp %h", bus.rd_data_o[31:0], e); end
    e = exp_q.pop_front(); checks++;
    if (bus.rd_data_o[63:32] !== e) begin errors++; $display("FAIL r3_keep: got %h exp %h", bus.rd_data_o[63:32], e); end
    bus.link_en_i = 1; bus.link_data_i = 32'h500;
    exp_q.push_back(32'h500); exp_q.push_back(32'h33);
    tick;
    bus.link_en_i = 0;
    set_rd(31, 3);
    e = exp_q.pop_front(); checks++;
    if (bus.rd_data_o[31:0] !== e) begin errors++; $display("FAIL link_only_r31: got %h exp %h", bus.rd_data_o[31:0], e); end
    e = exp_q.pop_front(); checks++;
    if (bus.rd_data_o[63:32] !== e) begin errors++; $display("FAIL link_only_r3: got %h exp %h", bus.rd_data_o[63:32], e); end
  endtask

  task automatic test_pend;
    bus.pend_set_i = 1; bus.pend_addr_i = 5'd9;
    set_rd(9, 9);
    checks++;
    if (bus.rd_pend_o !== 2'b00) begin errors++; $display("FAIL pend_not_bypassed: got %b exp 00", bus.rd_pend_o); end
    tick;
    bus.pend_set_i = 0;
    set_rd(9, 10);
    checks++;
    if (bus.rd_pend_o !== 2'b01) begin errors++; $display("FAIL pend_set: got %b exp 01", bus.rd_pend_o); end
    wr(9, 32'h99);
    tick;
    bus.wr_en_i = 0;
    set_rd(9, 10);
    checks++;
    if (bus.rd_pend_o !== 2'b00) begin errors++; $display("FAIL pend_wr_clear: got %b exp 00", bus.rd_pend_o); end
    wr(9, 32'h98); bus.pend_set_i = 1; bus.pend_addr_i = 5'd9;
    tick;
    bus.wr_en_i = 0; bus.pend_set_i = 0;
    set_rd(9, 10);
    checks++;
    if (bus.rd_pend_o !== 2'b01) begin errors++; $display("FAIL pend_set_wins: got %b exp 01", bus.rd_pend_o); end
    bus.pend_set_i = 1; bus.pend_addr_i = 5'd0;
    tick;
    bus.pend_set_i = 0;
    set_rd(0, 9);
    checks++;
    if (bus.rd_pend_o !== 2'b10) begin errors++; $display("FAIL pend_r0: got %b exp 10", bus.rd_pend_o); end
  endtask

  task automatic test_clear;
    logic [31:0] e;
    int a, n;
    for (int i = 1; i < 32; i++) begin
      wr(i, 32'hC000_0000 | 32'(i));
      exp_q.push_back(32'hC000_0000 | 32'(i)); adr_q.push_back(i);
      tick;
    end
    bus.wr_en_i = 0;
    bus.pend_set_i = 1; bus.pend_addr_i = 5'd4;
    tick;
    bus.pend_set_i = 0;
    while (exp_q.size() != 0) begin
      a = adr_q.pop_front();
      set_rd(0, a);
      e = exp_q.pop_front(); checks++;
      if (bus0.rd_data_o[63:32] !== e) begin errors++; $display("FAIL fill_r%0d: got %h exp %h", a, bus0.rd_data_o[63:32], e); end
    end
    set_rd(4, 0);
    checks++;
    if (bus.rd_pend_o[0] !== 1'b1) begin errors++; $display("FAIL pre_clr_pend: got %b exp 1", bus.rd_pend_o[0]); end
    bus.clr_i = 1;
    tick;
    bus.clr_i = 0;
    set_rd(4, 2);
    checks++;
    if (bus.rd_pend_o[0] !== 1'b0) begin errors++; $display("FAIL clr_pend_zero: got %b exp 0", bus.rd_pend_o[0]); end
    n = 0;
    while (bus.clr_busy_o === 1'b1 && n < 100) begin
      n++;
      if (n == 3) begin
        exp_q.push_back(32'h0); exp_q.push_back(32'hC000_0003);
        set_rd(2, 3);
        e = exp_q.pop_front(); checks++;
        if (bus.rd_data_o[31:0] !== e) begin errors++; $display("FAIL partial_r2: got %h exp %h", bus.rd_data_o[31:0], e); end
        e = exp_q.pop_front(); checks++;
        if (bus.rd_data_o[63:32] !== e) begin errors++; $display("FAIL partial_r3: got %h exp %h", bus.rd_data_o[63:32], e); end
      end
      if (n == 5) begin
        wr(6, 32'hBAD); bus.pend_set_i = 1; bus.pend_addr_i = 5'd8;
        exp_q.push_back(32'hC000_0006);
        set_rd(6, 0);
        e = exp_q.pop_front(); checks++;
        if (bus.rd_data_o[31:0] !== e) begin errors++; $display("FAIL clr_nobypass: got %h exp %h", bus.rd_data_o[31:0], e); end
      end
      tick;
      bus.wr_en_i = 0; bus.pend_set_i = 0;
    end
    checks++;
    if (n !== 31) begin errors++; $display("FAIL busy_len: got %0d exp 31", n); end
    for (int i = 0; i < 32; i += 2) begin
      exp_q.push_back(32'h0); exp_q.push_back(32'h0);
      set_rd(i, i + 1);
      e = exp_q.pop_front(); checks++;
      if (bus.rd_data_o[31:0] !== e) begin errors++; $display("FAIL cleared_r%0d: got %h exp %h", i, bus.rd_data_o[31:0], e); end
      e = exp_q.pop_front(); checks++;
      if (bus.rd_data_o[63:32] !== e) begin errors++; $display("FAIL cleared_r%0d: got %h exp %h", i + 1, bus.rd_data_o[63:32], e); end
    end
    set_rd(8, 6);
    checks++;
    if (bus.rd_pend_o !== 2'b00) begin errors++; $display("FAIL clr_pend_lost: got %b exp 00", bus.rd_pend_o); end
    wr(6, 32'h66); exp_q.push_back(32'h66);
    tick;
    bus.wr_en_i = 0;
    set_rd(6, 0);
    e = exp_q.pop_front(); checks++;
    if (bus0.rd_data_o[31:0] !== e) begin errors++; $display("FAIL post_clr_wr: got %h exp %h", bus0.rd_data_o[31:0], e); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] e;
    wr(20, 32'h20); tick;
    wr(31, 32'h31); tick;
    bus.wr_en_i = 0;
    bus.clr_i = 1;
    tick;
    bus.clr_i = 0;
    repeat (9) tick;
    checks++;
    if (bus.clr_busy_o !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b exp 1", bus.clr_busy_o); end
    #1 rst_i = 1'b0;
    #1;
    checks++;
    if (bus.clr_busy_o !== 1'b0) begin errors++; $display("FAIL async_busy: got %b exp 0", bus.clr_busy_o); end
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    set_rd(20, 31);
    e = exp_q.pop_front(); checks++;
    if (bus.rd_data_o[31:0] !== e) begin errors++; $display("FAIL rst_r20: got %h exp %h", bus.rd_data_o[31:0], e); end
    e = exp_q.pop_front(); checks++;
    if (bus.rd_data_o[63:32] !== e) begin errors++; $display("FAIL rst_r31: got %h exp %h", bus.rd_data_o[63:32], e); end
    rst_i = 1'b1;
    tick;
    checks++;
    if (bus.clr_busy_o !== 1'b0) begin errors++; $display("FAIL rst_idle: got %b exp 0", bus.clr_busy_o); end
    wr(12, 32'h12); exp_q.push_back(32'h12);
    tick;
    bus.wr_en_i = 0;
    set_rd(12, 0);
    e = exp_q.pop_front(); checks++;
    if (bus0.rd_data_o[31:0] !== e) begin errors++; $display("FAIL rst_wr: got %h exp %h", bus0.rd_data_o[31:0], e); end
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_bypass;
    test_link;
    test_pend;
    test_clear;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-port register file for the single-cycle CPU datapath. It provides NUM_RD combinational read ports, one general write port and one dedicated link-register write port for jump-and-link. Reads can optionally bypass same-cycle writes. A per-register pending scoreboard and a multi-cycle clear sequencer let the core track outstanding results and wipe the file without a reset.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- DEPTH, 32, number of registers; power of two, ≥ 4
- NUM_RD, 2, number of read ports, 1–4
- LINK_REG, DEPTH-1, index written by the link port
- BYPASS, 1, 1 = write-to-read forwarding enabled; 0 = reads return stored value
- AW (derived), $clog2(DEPTH)

Ports (clock is clk_i; reset is asynchronous, active-low, named rst_i):
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous active-low reset
- rd_addr_i  in  NUM_RD*AW  packed read addresses, port k at [k*AW +: AW]
- rd_data_o  out  NUM_RD*DATA_W  packed read data
- rd_pend_o  out  NUM_RD  scoreboard bit of each read address
- wr_en_i  in  1  general write enable
- wr_addr_i  in  AW  general write address
- wr_data_i  in  DATA_W  general write data
- link_en_i  in  1  link write enable
- link_data_i  in  DATA_W  return address to store in LINK_REG
- pend_set_i  in  1  mark register pend_addr_i as pending
- pend_addr_i  in  AW  register to mark pending
- clr_i  in  1  start clear sweep (pulse)
- clr_busy_o  out  1  sweep in progress

## Operation
- Register 0 is hard-wired zero. Reads of 0 return 0. Writes and pend_set to 0 are ignored. Its pending bit is always 0.
- Write priority: when wr_en_i and link_en_i both target LINK_REG in the same cycle, link_data_i is stored. Otherwise the two writes proceed independently.
- Link write is explicit. LINK_REG changes only when link_en_i=1 or a general write targets it.
- Read data is combinational from rd_addr_i.
- With BYPASS=1, if the address is being written this cycle with a nonzero address, rd_data_o returns the write data. The link port wins under the same priority as storage.
- Scoreboard: one bit per register.
  - pend_set_i sets the bit at the next edge.
  - Any accepted write to an address clears its bit.
  - If a set and a clear hit the same address in the same cycle, the set wins.
  - rd_pend_o[k] reflects the stored bit and is not bypassed.
- Clear FSM has two states, IDLE and CLEAR.
  - IDLE→CLEAR when clr_i=1. At that edge all scoreboard bits are zeroed and the counter is loaded with 1.
  - In CLEAR, each cycle zeroes register[cnt] and increments cnt. The FSM returns to IDLE after zeroing DEPTH-1.
  - During CLEAR, wr_en_i, link_en_i, pend_set_i and clr_i are ignored.
  - Reads return the stored contents, so they may be partially cleared. No bypass is applied.
- Reset (rst_i=0, asynchronous): all registers 0, all pending bits 0, FSM to IDLE, counter 0. Reset asserted mid-sweep aborts the sweep immediately.

## Timing
- Write latency: data is visible on a read of the stored value 1 cycle after the write edge. With BYPASS=1 it is visible in the same cycle.
- clr_busy_o is high from the edge accepting clr_i through the cycle in which register DEPTH-1 is zeroed. A sweep therefore lasts DEPTH-1 cycles.
- The first write accepted after a sweep is the one presented in the cycle after clr_busy_o falls.
- Reset values: rd_data_o = 0 and rd_pend_o = 0 for all addresses, clr_busy_o = 0.
- Counter width is AW. It must not wrap to 0 inside the sweep; the terminal compare is against DEPTH-1.

## Structure
- Shared package `rf_pkg`: clear-FSM state enum (IDLE, CLEAR), default DATA_W/DEPTH constants, and LINK_REG default shared with the control decoder.
- One sub-module, `rf_clear_seq`. It holds the FSM and counter and outputs a clear enable, a clear address and clr_busy_o.
- Storage, scoreboard and bypass muxes stay in the top module.

## Test plan
- Reset, then write 0xDEADBEEF to r5; read r5 on port 0 next cycle → 0xDEADBEEF. Read r0 after writing 0x1234 to r0 → 0.
- BYPASS=1: write 0xA5A5A5A5 to r7 while port 1 reads r7 → 0xA5A5A5A5 in the same cycle. BYPASS=0 → previous value 0.
- Same cycle: wr_en_i to r31 with 0x11, link_en_i with 0x400 → r31 = 0x400. Link-only write leaves r3 untouched.
- pend_set on r9 → rd_pend_o=1 next cycle. Write r9 → 0. Set and write r9 in the same cycle → bit stays 1.
- Fill r1..r31 with nonzero values, then pulse clr_i: clr_busy_o is high for 31 cycles and all reads return 0 afterwards. A write attempted mid-sweep is lost.
- Assert rst_i=0 mid-sweep at cnt=10: clr_busy_o falls asynchronously and all registers are 0. After release, the FSM is IDLE.
